// File: rtl/pma_lsu_sequencer_if.sv
// -----------------------------------------------------------------------------
// Module   : pma_lsu_sequencer_if
// Purpose  : LSU request/response and data-bus signals of the PMA LSU sequencer.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface pma_lsu_sequencer_if;
    logic        s_req_valid_i;
    logic        s_req_ready_o;
    logic [31:0] s_req_addr_i;
    logic        s_req_write_i;
    logic        s_flush_i;
    logic        s_bus_valid_o;
    logic        s_bus_ready_i;
    logic [31:0] s_bus_addr_o;
    logic        s_bus_write_o;
    logic        s_bus_rsp_i;
    logic        s_bus_err_i;
    logic        s_rsp_valid_o;
    logic        s_rsp_err_o;
    logic        s_rsp_pma_o;
    logic        s_busy_o;

    // Sequencer side.
    modport slave (
        input  s_req_valid_i, s_req_addr_i, s_req_write_i, s_flush_i,
               s_bus_ready_i, s_bus_rsp_i, s_bus_err_i,
        output s_req_ready_o, s_bus_valid_o, s_bus_addr_o, s_bus_write_o,
               s_rsp_valid_o, s_rsp_err_o, s_rsp_pma_o, s_busy_o
    );

    // LSU plus data bus side.
    modport master (
        output s_req_valid_i, s_req_addr_i, s_req_write_i, s_flush_i,
               s_bus_ready_i, s_bus_rsp_i, s_bus_err_i,
        input  s_req_ready_o, s_bus_valid_o, s_bus_addr_o, s_bus_write_o,
               s_rsp_valid_o, s_rsp_err_o, s_rsp_pma_o, s_busy_o
    );
endinterface

`default_nettype wire

// File: rtl/pma_lsu_sequencer.sv
// -----------------------------------------------------------------------------
// Module   : pma_lsu_sequencer (with pma_lsu_pkg and pma)
// Purpose  : Registers one LSU request, checks it against the PMA table and
//            faults, freely issues or serializes it on the data bus.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package pma_lsu_pkg;
    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
        logic        read_only;
        logic        idempotent;
        logic        executable;
    } pma_cfg_t;

    localparam pma_cfg_t [2:0] PMA_DEFAULT = {
        pma_cfg_t'{base: 32'h8000_0000, mask: 32'hFFFF_F000,
                   read_only: 1'b0, idempotent: 1'b0, executable: 1'b0},
        pma_cfg_t'{base: 32'h1000_0000, mask: 32'hFFF0_0000,
                   read_only: 1'b0, idempotent: 1'b1, executable: 1'b0},
        pma_cfg_t'{base: 32'h0000_0000, mask: 32'hFFF0_0000,
                   read_only: 1'b1, idempotent: 1'b1, executable: 1'b1}
    };
endpackage

// Region matcher: the lowest-numbered matching region decides the attributes.
module pma
    import pma_lsu_pkg::*;
#(
    parameter int                     ALIGN   = 10,
    parameter int                     REGIONS = 3,
    parameter pma_cfg_t [REGIONS-1:0] CFG     = PMA_DEFAULT,
    parameter bit                     FETCH   = 1'b0
) (
    input  wire logic [31:0] i_addr,
    input  wire logic        i_write,
    output logic             o_violation,
    output logic             o_idempotent
);
    localparam logic [31:0] c_align_mask = ~((32'h1 << ALIGN) - 32'h1);

    logic [REGIONS-1:0] w_hit;
    logic               w_any;
    logic               w_ro;
    logic               w_exec;

    for (genvar g = 0; g < REGIONS; g++) begin : g_region
        assign w_hit[g] = ((i_addr ^ CFG[g].base) & CFG[g].mask & c_align_mask) == 32'h0;
    end

    always_comb begin
        w_any        = 1'b0;
        w_ro         = 1'b0;
        w_exec       = 1'b0;
        o_idempotent = 1'b0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any        = 1'b1;
                w_ro         = CFG[i].read_only;
                w_exec       = CFG[i].executable;
                o_idempotent = CFG[i].idempotent;
            end
        end
    end

    assign o_violation = !w_any || (i_write && w_ro) || (FETCH && !w_exec);
endmodule

module pma_lsu_sequencer
    import pma_lsu_pkg::*;
#(
    parameter int                         PMA_ALIGN       = 10,
    parameter int                         PMA_REGIONS     = 3,
    parameter pma_cfg_t [PMA_REGIONS-1:0] PMA_CFG         = PMA_DEFAULT,
    parameter int                         MAX_OUTSTANDING = 2
) (
    input  wire logic            s_clk_i,
    input  wire logic            s_resetn_i,
    pma_lsu_sequencer_if.slave   seq_if
);
    localparam int                 c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_SERIAL = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t             r_state;
    logic [31:0]        r_addr;
    logic               r_write;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_bus_valid;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic               r_rsp_pma;

    logic w_violation;
    logic w_idem;
    logic w_accept;
    logic w_handshake;
    logic w_rsp;
    logic w_room;
    logic w_empty;
    logic w_abort;

    pma #(
        .ALIGN   (PMA_ALIGN),
        .REGIONS (PMA_REGIONS),
        .CFG     (PMA_CFG),
        .FETCH   (1'b0)
    ) u_pma (
        .i_addr       (r_addr),
        .i_write      (r_write),
        .o_violation  (w_violation),
        .o_idempotent (w_idem)
    );

    assign w_accept    = seq_if.s_req_valid_i && (r_state == ST_IDLE);
    assign w_handshake = r_bus_valid && seq_if.s_bus_ready_i;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign w_rsp       = seq_if.s_bus_rsp_i && (r_cnt != '0);
    assign w_room      = r_cnt < c_max;
    assign w_empty     = r_cnt == '0;
    assign w_abort     = seq_if.s_flush_i &&
                         (r_state == ST_CHECK || r_state == ST_DRAIN || r_state == ST_FAULT);

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_cnt <= '0;
        end else if (w_handshake && !w_rsp) begin
            r_cnt <= r_cnt + c_one;
        end else if (w_rsp && !w_handshake) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= 32'h0;
            r_write     <= 1'b0;
            r_bus_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_pma   <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp;
            r_rsp_err   <= w_rsp && seq_if.s_bus_err_i;
            r_rsp_pma   <= 1'b0;

            if (w_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_addr  <= seq_if.s_req_addr_i;
                            r_write <= seq_if.s_req_write_i;
                            r_state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (w_violation) begin
                            r_state <= ST_FAULT;
                        end else if (w_idem && w_room) begin
                            r_state     <= ST_ISSUE;
                            r_bus_valid <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_idem ? w_room : w_empty) begin
                            r_state     <= ST_ISSUE;
                            r_bus_valid <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        if (w_handshake) begin
                            r_bus_valid <= 1'b0;
                            r_state     <= w_idem ? ST_IDLE : ST_SERIAL;
                        end
                    end
                    ST_SERIAL: begin
                        if (w_empty) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_FAULT: begin
                        // Earlier bus responses drain first so ordering is kept.
                        if (w_empty) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_pma   <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_bus_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign seq_if.s_req_ready_o = (r_state == ST_IDLE);
    assign seq_if.s_bus_valid_o = r_bus_valid;
    assign seq_if.s_bus_addr_o  = r_addr;
    assign seq_if.s_bus_write_o = r_write;
    assign seq_if.s_rsp_valid_o = r_rsp_valid;
    assign seq_if.s_rsp_err_o   = r_rsp_err;
    assign seq_if.s_rsp_pma_o   = r_rsp_pma;
    assign seq_if.s_busy_o      = (r_state != ST_IDLE) || (r_cnt != '0);

`ifndef SYNTHESIS
    a_rsp_without_transfer : assert property (@(posedge s_clk_i) disable iff (!s_resetn_i)
        !(seq_if.s_bus_rsp_i && (r_cnt == '0)));
    a_cnt_in_range : assert property (@(posedge s_clk_i) disable iff (!s_resetn_i)
        r_cnt <= c_max);
`endif
endmodule

`default_nettype wire

// File: tb/tb_pma_lsu_sequencer.sv
// -----------------------------------------------------------------------------
// Module   : tb_pma_lsu_sequencer
// Purpose  : Directed self-checking bench for pma_lsu_sequencer.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pma_lsu_sequencer;
    import pma_lsu_pkg::*;

    localparam pma_cfg_t [2:0] c_cfg = {
        pma_cfg_t'{base: 32'h8000_0000, mask: 32'hFFFF_F000,
                   read_only: 1'b0, idempotent: 1'b0, executable: 1'b0},
        pma_cfg_t'{base: 32'h1000_0000, mask: 32'hFFF0_0000,
                   read_only: 1'b0, idempotent: 1'b1, executable: 1'b0},
        pma_cfg_t'{base: 32'h0000_0000, mask: 32'hFFF0_0000,
                   read_only: 1'b1, idempotent: 1'b1, executable: 1'b0}
    };

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pma_lsu_sequencer_if seq_if ();

    pma_lsu_sequencer #(
        .PMA_ALIGN       (10),
        .PMA_REGIONS     (3),
        .PMA_CFG         (c_cfg),
        .MAX_OUTSTANDING (2)
    ) u_dut (
        .s_clk_i    (clk),
        .s_resetn_i (rst_n),
        .seq_if     (seq_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single edge; the sequencer must be ready.
    task automatic accept(input logic [31:0] addr, input logic wr);
        seq_if.s_req_valid_i = 1'b1;
        seq_if.s_req_addr_i  = addr;
        seq_if.s_req_write_i = wr;
        chk("req_ready_before_accept", {31'h0, seq_if.s_req_ready_o}, 32'h1);
        tick();
        seq_if.s_req_valid_i = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        seq_if.s_req_valid_i = 1'b0;
        seq_if.s_req_addr_i  = 32'h0;
        seq_if.s_req_write_i = 1'b0;
        seq_if.s_flush_i     = 1'b0;
        seq_if.s_bus_ready_i = 1'b1;
        seq_if.s_bus_rsp_i   = 1'b0;
        seq_if.s_bus_err_i   = 1'b0;

        tick();
        tick();
        chk("rst_bus_valid", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        chk("rst_rsp_valid", {31'h0, seq_if.s_rsp_valid_o}, 32'h0);
        chk("rst_busy",      {31'h0, seq_if.s_busy_o},      32'h0);
        chk("rst_req_ready", {31'h0, seq_if.s_req_ready_o}, 32'h1);
        rst_n = 1'b1;
        tick();

        // 1: idempotent write, immediate bus ready, response two cycles later
        accept(32'h1000_0040, 1'b1);
        chk("t1_check_bus_valid", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        chk("t1_check_busy",      {31'h0, seq_if.s_busy_o},      32'h1);
        tick();
        chk("t1_issue_bus_valid", {31'h0, seq_if.s_bus_valid_o}, 32'h1);
        chk("t1_bus_addr",        seq_if.s_bus_addr_o,          32'h1000_0040);
        chk("t1_bus_write",       {31'h0, seq_if.s_bus_write_o}, 32'h1);
        tick();
        chk("t1_after_hs_valid",  {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        chk("t1_outstanding",     {31'h0, seq_if.s_busy_o},      32'h1);
        chk("t1_ready_again",     {31'h0, seq_if.s_req_ready_o}, 32'h1);
        tick();
        seq_if.s_bus_rsp_i = 1'b1;
        tick();
        seq_if.s_bus_rsp_i = 1'b0;
        chk("t1_rsp_valid", {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t1_rsp_err",   {31'h0, seq_if.s_rsp_err_o},   32'h0);
        chk("t1_idle",      {31'h0, seq_if.s_busy_o},      32'h0);
        tick();
        chk("t1_rsp_pulse", {31'h0, seq_if.s_rsp_valid_o}, 32'h0);

        // 2: three idempotent reads with responses withheld
        accept(32'h1000_0000, 1'b0);
        tick();
        chk("t2_a_issue", {31'h0, seq_if.s_bus_valid_o}, 32'h1);
        tick();
        accept(32'h1000_0000, 1'b0);
        tick();
        chk("t2_b_issue", {31'h0, seq_if.s_bus_valid_o}, 32'h1);
        tick();
        accept(32'h1000_0000, 1'b0);
        tick();
        chk("t2_c_drain0", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        tick();
        chk("t2_c_drain1", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        seq_if.s_bus_rsp_i = 1'b1;
        seq_if.s_bus_err_i = 1'b1;
        tick();
        seq_if.s_bus_rsp_i = 1'b0;
        seq_if.s_bus_err_i = 1'b0;
        chk("t2_rsp0_valid",  {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t2_rsp0_err",    {31'h0, seq_if.s_rsp_err_o},   32'h1);
        chk("t2_c_still_held", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        tick();
        chk("t2_c_issue", {31'h0, seq_if.s_bus_valid_o}, 32'h1);
        tick();
        seq_if.s_bus_rsp_i = 1'b1;
        tick();
        chk("t2_rsp1_valid", {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t2_rsp1_err",   {31'h0, seq_if.s_rsp_err_o},   32'h0);
        tick();
        seq_if.s_bus_rsp_i = 1'b0;
        chk("t2_rsp2_valid", {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        tick();
        chk("t2_idle", {31'h0, seq_if.s_busy_o}, 32'h0);

        // 3: non-idempotent read waits for empty pipe and serializes
        accept(32'h1000_0000, 1'b0);
        tick();
        tick();
        accept(32'h8000_0010, 1'b0);
        tick();
        chk("t3_drain0", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        tick();
        chk("t3_drain1", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        seq_if.s_bus_rsp_i = 1'b1;
        tick();
        seq_if.s_bus_rsp_i = 1'b0;
        chk("t3_first_rsp", {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t3_drain2",    {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        tick();
        chk("t3_issue",     {31'h0, seq_if.s_bus_valid_o}, 32'h1);
        chk("t3_bus_addr",  seq_if.s_bus_addr_o,          32'h8000_0010);
        tick();
        chk("t3_serial_valid", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        chk("t3_serial_ready", {31'h0, seq_if.s_req_ready_o}, 32'h0);
        tick();
        chk("t3_serial_ready2", {31'h0, seq_if.s_req_ready_o}, 32'h0);
        seq_if.s_bus_rsp_i = 1'b1;
        tick();
        seq_if.s_bus_rsp_i = 1'b0;
        chk("t3_serial_rsp",    {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t3_serial_ready3", {31'h0, seq_if.s_req_ready_o}, 32'h0);
        tick();
        chk("t3_ready_done", {31'h0, seq_if.s_req_ready_o}, 32'h1);
        chk("t3_idle",       {31'h0, seq_if.s_busy_o},      32'h0);

        // 4: read-only write and unmapped read both fault at N+3
        accept(32'h0000_0100, 1'b1);
        tick();
        chk("t4_w_fault_wait", {31'h0, seq_if.s_rsp_valid_o}, 32'h0);
        tick();
        chk("t4_w_rsp_valid", {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t4_w_rsp_pma",   {31'h0, seq_if.s_rsp_pma_o},   32'h1);
        chk("t4_w_rsp_err",   {31'h0, seq_if.s_rsp_err_o},   32'h0);
        chk("t4_w_no_bus",    {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        accept(32'h2000_0000, 1'b0);
        chk("t4_r_pulse_end", {31'h0, seq_if.s_rsp_valid_o}, 32'h0);
        tick();
        chk("t4_r_no_bus",    {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        tick();
        chk("t4_r_rsp_valid", {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t4_r_rsp_pma",   {31'h0, seq_if.s_rsp_pma_o},   32'h1);

        // 5: fault waits behind an outstanding bus transfer
        accept(32'h1000_0000, 1'b0);
        tick();
        chk("t5_issue", {31'h0, seq_if.s_bus_valid_o}, 32'h1);
        tick();
        accept(32'h0000_0100, 1'b1);
        tick();
        chk("t5_fault_wait0", {31'h0, seq_if.s_rsp_valid_o}, 32'h0);
        tick();
        chk("t5_fault_wait1", {31'h0, seq_if.s_rsp_valid_o}, 32'h0);
        seq_if.s_bus_rsp_i = 1'b1;
        tick();
        seq_if.s_bus_rsp_i = 1'b0;
        chk("t5_bus_rsp_first", {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t5_bus_rsp_pma",   {31'h0, seq_if.s_rsp_pma_o},   32'h0);
        tick();
        chk("t5_fault_rsp",     {31'h0, seq_if.s_rsp_valid_o}, 32'h1);
        chk("t5_fault_pma",     {31'h0, seq_if.s_rsp_pma_o},   32'h1);
        tick();
        chk("t5_quiet", {31'h0, seq_if.s_rsp_valid_o}, 32'h0);

        // 6a: flush in CHECK discards the request
        accept(32'h1000_0000, 1'b0);
        seq_if.s_flush_i = 1'b1;
        tick();
        seq_if.s_flush_i = 1'b0;
        chk("t6_flush_ready", {31'h0, seq_if.s_req_ready_o}, 32'h1);
        chk("t6_flush_bus",   {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        chk("t6_flush_busy",  {31'h0, seq_if.s_busy_o},      32'h0);
        tick();
        chk("t6_flush_bus2",  {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        chk("t6_flush_rsp",   {31'h0, seq_if.s_rsp_valid_o}, 32'h0);

        // 6b: asynchronous reset while ISSUE is stalled with one outstanding
        accept(32'h1000_0000, 1'b0);
        tick();
        tick();
        seq_if.s_bus_ready_i = 1'b0;
        accept(32'h1000_0004, 1'b0);
        tick();
        chk("t6_stall_valid", {31'h0, seq_if.s_bus_valid_o}, 32'h1);
        tick();
        chk("t6_stall_hold",  {31'h0, seq_if.s_bus_valid_o}, 32'h1);
        chk("t6_stall_addr",  seq_if.s_bus_addr_o,          32'h1000_0004);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_bus_valid", {31'h0, seq_if.s_bus_valid_o}, 32'h0);
        chk("t6_rst_busy",      {31'h0, seq_if.s_busy_o},      32'h0);
        chk("t6_rst_ready",     {31'h0, seq_if.s_req_ready_o}, 32'h1);
        tick();
        rst_n = 1'b1;
        seq_if.s_bus_ready_i = 1'b1;
        tick();
        chk("t6_post_rst_busy", {31'h0, seq_if.s_busy_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
